// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder split into STAGES registered slices, carry flopped between slices.
// Optional subtract and signed overflow with `define PIPELINED_ADDER_SUB_EN.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             z,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    localparam int CHUNK = WIDTH / STAGES;

    logic [WIDTH-1:0]  b_in;
    logic              c_in;
    logic [STAGES:0]   vin;
    logic [STAGES-1:0] v;
    logic [WIDTH:0]    nxt;

`ifdef PIPELINED_ADDER_SUB_EN
    logic nxt_ovf;
    // subtract folds into operand inversion at issue, so sub rides along inside the skewed y slices
    assign b_in = sub ? ~y : y;
    assign c_in = sub | z;
`else
    assign b_in = y;
    assign c_in = z;
`endif

    assign vin       = {v, in_valid};
    assign out_valid = vin[STAGES];

    always_ff @(posedge clk)
        v <= rst ? '0 : vin[STAGES-1:0];

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic [CHUNK-1:0] xs;
        logic [CHUNK-1:0] ys;
        logic             cin;
        logic [CHUNK:0]   r;
        if (k == 0) begin : g_ns
            assign xs  = x[CHUNK-1:0];
            assign ys  = b_in[CHUNK-1:0];
            assign cin = c_in;
        end else begin : g_sk
            logic [CHUNK-1:0] xd [k];
            logic [CHUNK-1:0] yd [k];
            always_ff @(posedge clk)
                if (rst) begin
                    for (int j = 0; j < k; j++) begin
                        xd[j] <= '0;
                        yd[j] <= '0;
                    end
                end else begin
                    xd[0] <= x[k*CHUNK +: CHUNK];
                    yd[0] <= b_in[k*CHUNK +: CHUNK];
                    for (int j = 1; j < k; j++) begin
                        xd[j] <= xd[j-1];
                        yd[j] <= yd[j-1];
                    end
                end
            assign xs  = xd[k-1];
            assign ys  = yd[k-1];
            assign cin = g_st[k-1].g_mid.co;
        end
        assign r = {1'b0, xs} + {1'b0, ys} + {{CHUNK{1'b0}}, cin};
        if (k < STAGES - 1) begin : g_mid
            localparam int N = STAGES - 2 - k;
            logic             co;
            logic [CHUNK-1:0] ps;
            always_ff @(posedge clk)
                {co, ps} <= rst ? '0 : r;
            if (N == 0) begin : g_nd
                assign nxt[k*CHUNK +: CHUNK] = ps;
            end else begin : g_dd
                logic [CHUNK-1:0] dd [N];
                always_ff @(posedge clk)
                    if (rst) begin
                        for (int j = 0; j < N; j++)
                            dd[j] <= '0;
                    end else begin
                        dd[0] <= ps;
                        for (int j = 1; j < N; j++)
                            dd[j] <= dd[j-1];
                    end
                assign nxt[k*CHUNK +: CHUNK] = dd[N-1];
            end
        end else begin : g_last
            assign nxt[WIDTH:k*CHUNK] = r;
`ifdef PIPELINED_ADDER_SUB_EN
            assign nxt_ovf = (xs[CHUNK-1] == ys[CHUNK-1]) && (r[CHUNK-1] != xs[CHUNK-1]);
`endif
        end
    end

    always_ff @(posedge clk)
        if (rst) begin
            {carry, sum} <= '0;
`ifdef PIPELINED_ADDER_SUB_EN
            ovf <= 1'b0;
`endif
        end else if (vin[STAGES-1]) begin
            {carry, sum} <= nxt;
`ifdef PIPELINED_ADDER_SUB_EN
            ovf <= nxt_ovf;
`endif
        end
endmodule
